c1_slave_port: RTL

C1_SLAVE_PORT -- requirements
Module: c1_slave_port

---
 rtl/c1_slave_port.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/c1_slave_port.sv
// -----------------------------------------------------------------------------
// c1_slave_port
//   Slave side of the C1 bus. It captures a two-cycle C1 request, turns the
//   bus around, hands the request to the cache core through a valid/ready
//   port, waits for the core's completion pulse, and then drives the C1
//   response (WRITE32_RESP command plus up to two data words).
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   address         : tag+set in command cycle, offset in low bits next cycle
//   data            : C1 data bus (bidirectional)
//   command         : C1 command bus (bidirectional)
//   req_valid/ready : request handshake to the cache core
//   req_cmd/addr    : captured command and {tag_set, offset}
//   req_wdata       : {word2, word1} for writes, zero otherwise
//   resp_valid      : one-cycle completion pulse from the core
//   resp_rdata      : read data qualified by resp_valid
//   o_dbg_state     : current FSM state
//   o_dbg_cmd_oe    : this port is driving the command bus
//   o_dbg_data_oe   : this port is driving the data bus
//
// Handshake: a request moves to the core on any posedge where req_valid and
// req_ready are both high; req_valid is only high in ISSUE and req_* are held
// stable until that edge. resp_valid is looked at only in WAIT.
// -----------------------------------------------------------------------------
module c1_slave_port #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                     data,
  inout  wire  [2:0]                              command,
  output logic                                    req_valid,
  input  logic                                    req_ready,
  output logic [2:0]                              req_cmd,
  output logic [MEM_ADDR_SIZE-1:0]                req_addr,
  output logic [2*BUS_SIZE-1:0]                   req_wdata,
  input  logic                                    resp_valid,
  input  logic [2*BUS_SIZE-1:0]                   resp_rdata,
  output logic [2:0]                              o_dbg_state,
  output logic                                    o_dbg_cmd_oe,
  output logic                                    o_dbg_data_oe
);

  localparam int TS_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  localparam logic [2:0] C_NOP    = 3'd0;
  localparam logic [2:0] C_READ8  = 3'd1;
  localparam logic [2:0] C_READ32 = 3'd3;
  localparam logic [2:0] C_WRITE8 = 3'd5;
  localparam logic [2:0] C_RESP   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR2 = 3'd1,
    S_TURN  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP1 = 3'd5,
    S_RESP2 = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [2:0]               r_cmd;
  logic [TS_W-1:0]          r_tag_set;
  logic [CACHE_OFFSET_SIZE-1:0] r_offset;
  logic [BUS_SIZE-1:0]      r_word1;
  logic [BUS_SIZE-1:0]      r_word2;
  logic [2*BUS_SIZE-1:0]    r_rdata;

  logic                     w_cmd_oe;
  logic                     w_data_oe;
  logic [2:0]               w_cmd_out;
  logic [BUS_SIZE-1:0]      w_data_out;
  logic                     w_r_is_write;
  logic                     w_bus_is_write;

  // Commands 5..7 carry write data; 1..3 are reads, 4 is INV_LINE.
  assign w_r_is_write   = (r_cmd >= C_WRITE8);
  assign w_bus_is_write = (command >= C_WRITE8);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_cmd_oe   = 1'b0;
    w_data_oe  = 1'b0;
    w_cmd_out  = C_NOP;
    w_data_out = '0;
    req_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Only defined, non-NOP commands start a request; X/Z match no item.
        case (command)
          3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: w_next = S_ADDR2;
          default:                                  w_next = S_IDLE;
        endcase
      end
      S_ADDR2: w_next = S_TURN;
      S_TURN:  w_next = S_ISSUE;
      S_ISSUE: begin
        w_cmd_oe  = 1'b1;
        req_valid = 1'b1;
        if (req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_cmd_oe = 1'b1;
        if (resp_valid) w_next = S_RESP1;
      end
      S_RESP1: begin
        w_cmd_oe  = 1'b1;
        w_cmd_out = C_RESP;
        if (!w_r_is_write && (r_cmd != 3'd4)) begin
          w_data_oe = 1'b1;
          if (r_cmd == C_READ8) begin
            w_data_out = {{(BUS_SIZE-8){1'b0}}, r_rdata[7:0]};
          end else begin
            w_data_out = r_rdata[BUS_SIZE-1:0];
          end
        end
        w_next = (r_cmd == C_READ32) ? S_RESP2 : S_IDLE;
      end
      S_RESP2: begin
        w_cmd_oe   = 1'b1;
        w_cmd_out  = C_RESP;
        w_data_oe  = 1'b1;
        w_data_out = r_rdata[2*BUS_SIZE-1:BUS_SIZE];
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and response data latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd     <= '0;
      r_tag_set <= '0;
      r_offset  <= '0;
      r_word1   <= '0;
      r_word2   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next == S_ADDR2) begin
            r_cmd     <= command;
            r_tag_set <= address;
            r_offset  <= '0;
            // Non-writes keep the write words at zero so req_wdata reads 0.
            r_word1   <= w_bus_is_write ? data : '0;
            r_word2   <= '0;
          end
        end
        S_ADDR2: begin
          r_offset <= address[CACHE_OFFSET_SIZE-1:0];
          if (w_r_is_write) r_word2 <= data;
        end
        S_WAIT: begin
          if (resp_valid) r_rdata <= resp_rdata;
        end
        default: ;
      endcase
    end
  end

  assign req_cmd   = r_cmd;
  assign req_addr  = {r_tag_set, r_offset};
  assign req_wdata = {r_word2, r_word1};

  assign command = w_cmd_oe  ? w_cmd_out  : 3'bzzz;
  assign data    = w_data_oe ? w_data_out : {BUS_SIZE{1'bz}};

  assign o_dbg_state   = r_state;
  assign o_dbg_cmd_oe  = w_cmd_oe;
  assign o_dbg_data_oe = w_data_oe;

endmodule
